// File: rtl/iob_f2s_event_sync.sv
`default_nettype none
// ============================================================================
// Module   : iob_f2s_event_sync
// Brief    : Multi-channel fast-to-slow event synchronizer. Each channel gives a
//            stretched level, a one-cycle strobe and a saturating event counter.
// Revision : 1.0
// ============================================================================
module iob_f2s_event_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               cke_i,
    input  logic [W-1:0]       value_i,
    input  logic               cnt_clr_i,
    output logic [W-1:0]       value_o,
    output logic [W-1:0]       pulse_o,
    output logic [W*CNT_W-1:0] cnt_o,
    output logic [W-1:0]       ovf_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    genvar k;
    generate
        for (k = 0; k < W; k++) begin : g_chan
            logic              set;
            logic [STAGES-1:0] chain_q;
            logic              sync;
            logic              evt;
            logic              prev_q;
            logic              pulse_q;
            logic [CNT_W-1:0]  cnt_q;
            logic [CNT_W-1:0]  cnt_d;
            logic              ovf_q;
            logic              ovf_d;

            assign set = value_i[k];

            // Every chain bit is async-preset by the event and async-cleared by reset.
            always_ff @(posedge clk_i or posedge arst_i or posedge set) begin
                if (arst_i) begin
                    chain_q <= '0;
                end else if (set) begin
                    chain_q <= '1;
                end else if (cke_i) begin
                    chain_q <= {chain_q[STAGES-2:0], 1'b0};
                end
            end

            // A flop whose set is still active when reset releases goes straight to 1;
            // the OR term reproduces that without needing an edge on the set input.
            assign sync = chain_q[STAGES-1] | (value_i[k] & ~arst_i);
            assign evt  = sync & ~prev_q;

            always_comb begin
                cnt_d = cnt_q;
                ovf_d = ovf_q;
                if (cnt_clr_i) begin
                    cnt_d = evt ? c_cnt_one : '0;
                    ovf_d = 1'b0;
                end else if (evt) begin
                    if (cnt_q == c_cnt_max) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    prev_q  <= 1'b0;
                    pulse_q <= 1'b0;
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                end else if (cke_i) begin
                    prev_q  <= sync;
                    pulse_q <= evt;
                    cnt_q   <= cnt_d;
                    ovf_q   <= ovf_d;
                end
            end

            assign value_o[k]                 = sync;
            assign pulse_o[k]                 = pulse_q;
            assign cnt_o[k*CNT_W +: CNT_W]    = cnt_q;
            assign ovf_o[k]                   = ovf_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_iob_f2s_event_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_f2s_event_sync
// Brief    : Directed bench: dut_a (W=4, STAGES=2, CNT_W=2), dut_b (W=1, STAGES=3).
// Revision : 1.0
// ============================================================================
module tb_iob_f2s_event_sync;

    logic       clk;
    logic       rst;
    logic       cke;
    logic       clr;
    logic [3:0] va;
    logic [0:0] vb;
    logic [3:0] vo_a, po_a, ovf_a;
    logic [7:0] cnt_a;
    logic [0:0] vo_b, po_b, ovf_b;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    iob_f2s_event_sync #(.W(4), .STAGES(2), .CNT_W(2)) dut_a (
        .clk_i(clk), .arst_i(rst), .cke_i(cke), .value_i(va), .cnt_clr_i(clr),
        .value_o(vo_a), .pulse_o(po_a), .cnt_o(cnt_a), .ovf_o(ovf_a)
    );

    iob_f2s_event_sync #(.W(1), .STAGES(3), .CNT_W(8)) dut_b (
        .clk_i(clk), .arst_i(rst), .cke_i(cke), .value_i(vb), .cnt_clr_i(clr),
        .value_o(vo_b), .pulse_o(po_b), .cnt_o(cnt_b), .ovf_o(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [3:0] m);
        va = va | m;
        #1;
        va = va & ~m;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; cke = 1'b1; clr = 1'b0; va = '0; vb = '0;
        #2;
        rst = 1'b1; va = 4'hF; vb = 1'b1;
        tick(); tick();
        chk("rst_vo_a", vo_a, 0);
        chk("rst_po_a", po_a, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_vo_b", vo_b, 0);
        chk("rst_cnt_b", cnt_b, 0);

        // Release reset with channel 0 still asserted
        va = 4'b0001; vb = 1'b0; rst = 1'b0;
        #1;
        chk("rel_vo_a", vo_a, 4'b0001);
        tick();
        chk("rel_po_a", po_a, 4'b0001);
        chk("rel_cnt_a", cnt_a, 8'h01);
        va = 4'b0000;
        tick();
        chk("rel_po_off", po_a, 0);
        chk("rel_stretch1", vo_a, 4'b0001);
        tick();
        chk("rel_stretch2", vo_a, 0);
        tick();

        // Short pulse, STAGES=3
        vb = 1'b1; #1; vb = 1'b0; #1;
        chk("sp_vo_b", vo_b, 1);
        tick();
        chk("sp_po_b", po_b, 1);
        chk("sp_cnt_b", cnt_b, 1);
        tick();
        chk("sp_po_b_off", po_b, 0);
        chk("sp_vo_b_e2", vo_b, 1);
        tick();
        chk("sp_vo_b_e3", vo_b, 0);
        chk("sp_cnt_b_end", cnt_b, 1);

        // Merge: low for only 2 enabled edges between pulses
        pulse_a(4'b0010);
        tick();
        chk("mg_cnt1", cnt_a, 8'h05);
        tick();
        pulse_a(4'b0010);
        tick();
        chk("mg_no_strobe", po_a, 0);
        tick(); tick(); tick();
        chk("mg_cnt_end", cnt_a, 8'h05);

        // Distinct: low for 3 enabled edges
        pulse_a(4'b0010);
        tick();
        chk("ds_cnt2", cnt_a, 8'h09);
        tick(); tick(); tick();
        pulse_a(4'b0010);
        tick();
        chk("ds_po", po_a, 4'b0010);
        chk("ds_cnt3", cnt_a, 8'h0D);
        tick(); tick(); tick();
        chk("ds_ovf", ovf_a, 0);

        // Saturation on channel 2 (CNT_W=2)
        for (int i = 1; i <= 5; i++) begin
            pulse_a(4'b0100);
            tick();
            chk("sat_cnt", cnt_a[5:4], (i > 3) ? 3 : i);
            chk("sat_ovf", ovf_a[2], (i >= 4) ? 1 : 0);
            tick(); tick(); tick();
        end
        chk("sat_cnt_all", cnt_a, 8'h3D);
        chk("sat_ovf_all", ovf_a, 4'b0100);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt_a", cnt_a, 0);
        chk("clr_ovf_a", ovf_a, 0);
        chk("clr_cnt_b", cnt_b, 0);

        // Clear coincident with an event
        pulse_a(4'b0100);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrev_cnt", cnt_a, 8'h10);
        chk("clrev_po", po_a, 4'b0100);
        tick(); tick(); tick();

        // Clock enable held low across a pulse
        cke = 1'b0;
        pulse_a(4'b0001);
        #1;
        chk("cke_vo_async", vo_a, 4'b0001);
        tick(); tick(); tick();
        chk("cke_no_po", po_a, 0);
        chk("cke_vo_hold", vo_a, 4'b0001);
        chk("cke_cnt_hold", cnt_a, 8'h10);
        cke = 1'b1;
        tick();
        chk("cke_po", po_a, 4'b0001);
        chk("cke_cnt", cnt_a, 8'h11);
        cke = 1'b0;
        tick(); tick();
        chk("cke_stretch_hold", vo_a, 4'b0001);
        cke = 1'b1;
        tick();
        chk("cke_stretch_end", vo_a, 0);
        tick(); tick();

        // Multi-channel: simultaneous then staggered
        pulse_a(4'b1001);
        tick();
        chk("mc_sim_po", po_a, 4'b1001);
        chk("mc_sim_cnt", cnt_a, 8'h52);
        tick(); tick(); tick();
        pulse_a(4'b0001);
        tick();
        chk("mc_stag_po0", po_a, 4'b0001);
        pulse_a(4'b1000);
        tick();
        chk("mc_stag_po3", po_a, 4'b1000);
        tick(); tick(); tick();
        chk("mc_stag_cnt", cnt_a, 8'h93);

        // Held-high input is exactly one event
        va = 4'b1000;
        tick();
        chk("hold_po", po_a, 4'b1000);
        tick(); tick(); tick();
        chk("hold_po_off", po_a, 0);
        chk("hold_vo", vo_a, 4'b1000);
        chk("hold_cnt", cnt_a, 8'hD3);
        va = 4'b0000;
        tick(); tick(); tick(); tick();

        // Reset mid-operation drops a pending event
        pulse_a(4'b0001);
        rst = 1'b1; #1; rst = 1'b0; #1;
        chk("mid_rst_vo", vo_a, 0);
        tick();
        chk("mid_rst_po", po_a, 0);
        chk("mid_rst_cnt", cnt_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iob_f2s_event_sync.md
# iob_f2s_event_sync

Multi-channel fast-to-slow event synchronizer. Each channel captures an asynchronous event of any width on `value_i[k]`, including glitch-short pulses from a faster domain. It does this with a preset-capture shift chain of `STAGES` flops. The block presents the event in the `clk_i` domain in three forms: a stretched level, a one-cycle strobe, and a saturating per-channel event counter with a sticky overflow flag. It sits at the boundary where fast-domain interrupts and status pulses enter a slower peripheral or CSR domain.

## Interface
- `W`, 1: number of independent channels (≥1).
- `STAGES`, 2: capture/synchronizer chain depth (≥2).
- `CNT_W`, 8: event counter width per channel (≥1).
- `clk_i` in 1: destination-domain clock.
- `arst_i` in 1: asynchronous active-high reset; clears all state; dominates `value_i`.
- `cke_i` in 1: clock enable; when low, no synchronous state changes; async preset/reset still act.
- `value_i` in W: asynchronous event inputs, active-high, any pulse width above flop minimum async-set width.
- `cnt_clr_i` in 1: synchronous clear of all counters and overflow flags, sampled on enabled edges.
- `value_o` out W: stretched synchronized level per channel (last chain stage).
- `pulse_o` out W: registered one-cycle strobe per detected event.
- `cnt_o` out W*CNT_W: event counts; channel k at bits [k*CNT_W +: CNT_W].
- `ovf_o` out W: sticky per-channel counter overflow.

## Operation
- Capture chain, per channel: `chain[0..STAGES-1]`.
  - While `arst_i`=1: all bits forced 0.
  - Else while `value_i[k]`=1: all bits asynchronously preset to 1.
  - Else, on an enabled edge: `chain[0]`<=0 and `chain[j]`<=`chain[j-1]`.
- `value_o[k]` = `chain[STAGES-1]`. It asserts asynchronously with `value_i[k]` (no arst). It deasserts on the STAGES-th enabled edge after `value_i[k]` falls.
- Edge detector, per channel: `prev[k]` <= `value_o[k]` on enabled edges. An event is `value_o[k]` & ~`prev[k]` sampled at the edge. `pulse_o[k]` is registered from the event and is high for exactly one enabled cycle.
- Counter, per channel:
  - On an enabled edge with `cnt_clr_i`=1: count <= event ? 1 : 0, and `ovf_o[k]`<=0.
  - Else, on an event: if count = 2^CNT_W-1, count holds and `ovf_o[k]`<=1; otherwise count+1.
  - Counting is unsigned, with no wrap-around.
- Event merging: if `value_i[k]` re-asserts before `prev[k]` has sampled 0, the two pulses are one event. Distinct events require `value_i[k]` low across ≥ STAGES+1 enabled edges.
- `value_i[k]` held high continuously: `value_o[k]` stays high; exactly one event.
- Channels are fully independent; `cnt_clr_i` is global.
- Reset values: `value_o`=0, `pulse_o`=0, `cnt_o`=0, `ovf_o`=0, `prev`=0.
- Reset mid-operation: all state clears immediately, pending events are lost. If `value_i[k]`=1 when `arst_i` falls, the chain presets at once and one event is counted at the next enabled edge.

## Timing
- Event latency: `value_i` rises between enabled edges E0 and E1.
  - `value_o` is high before E1.
  - At E1: `prev`<=1, `pulse_o`<=1, count is updated.
  - At E2: `pulse_o`<=0.
- Stretch: `value_o` falls at enabled edge E_S, counted from the first edge after `value_i` falls (E_1..E_STAGES).
- `cke_i`=0 freezes chain shifting, `prev`, `pulse_o`, counters and flags. It does not block the async preset. Latency counts in enabled edges only.
- `cnt_clr_i` takes effect at the same enabled edge; the cleared value is visible after that edge.

## Test plan
- Reset: assert `arst_i` with `value_i`=all 1s → all outputs 0. Release with `value_i[0]`=1 → `value_o[0]`=1 immediately; `pulse_o[0]` high one cycle after the next enabled edge; `cnt_o[0]`=1.
- Short pulse: 1 ns pulse on `value_i[0]` between edges, STAGES=3 → `value_o[0]` high until the 3rd edge after the pulse; one `pulse_o` strobe; count=1.
- Merge/spacing, STAGES=2:
  - Two pulses with `value_i` low for 2 enabled edges between them → count=1.
  - Two pulses with `value_i` low for 3 enabled edges between them → count=2.
- Saturation, CNT_W=2: 5 separated events → `cnt_o`=3 and `ovf_o`=1 after the 4th event. Then `cnt_clr_i` → 0/0. Clear coincident with an event → count=1.
- Clock enable: hold `cke_i`=0 across a pulse → `value_o` stays high, no strobe. Re-enable → strobe on the first enabled edge; stretch counts only enabled edges.
- Multi-channel, W=4: simultaneous and staggered events on channels 0 and 3 → independent strobes and counts; channels 1 and 2 stay 0.
